// File: rtl/trigger_arm_controller_pkg.sv
// Shared types and constants for the trigger arm controller.
// Holds the state encoding, default sizing and the counter saturation helper.
package trigger_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;

    // All-ones value of a counter of the given width.
    function automatic logic [63:0] cnt_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/trigger_arm_controller_if.sv
// Control/status bundle of the trigger arm controller.
// master drives the trigger lines and configuration, slave is the controller.
interface trigger_arm_controller_if
    import trigger_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    logic [NUM_CH-1:0] signal_in;
    logic [NUM_CH-1:0] ch_mask;
    logic [CNT_W-1:0]  timeout_cycles;
    logic [CNT_W-1:0]  holdoff_cycles;
    logic              auto_rearm;
    logic              arm;
    logic              abort;
    logic              armed;
    logic              busy;
    logic              fired;
    logic [NUM_CH-1:0] fired_ch;
    logic              timed_out;
    logic [CNT_W-1:0]  trig_count;

    modport master (
        output signal_in, ch_mask, timeout_cycles, holdoff_cycles, auto_rearm, arm, abort,
        input  armed, busy, fired, fired_ch, timed_out, trig_count
    );

    modport slave (
        input  signal_in, ch_mask, timeout_cycles, holdoff_cycles, auto_rearm, arm, abort,
        output armed, busy, fired, fired_ch, timed_out, trig_count
    );
endinterface

// File: rtl/trigger_arm_controller_edge.sv
// Per-channel rising-edge detector; edge vector is combinational off the previous sample.
// No backpressure; the previous-sample registers load every cycle.
module rising_edge_bank
    import trigger_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] signal_in,
    input  logic [NUM_CH-1:0] mask,
    output logic [NUM_CH-1:0] edge_vec
);
    logic [NUM_CH-1:0] prev;

    // Reset to ones so a line already high when reset drops is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '1;
        end else begin
            prev <= signal_in;
        end
    end

    assign edge_vec = ~prev & signal_in & mask;

endmodule

// File: rtl/trigger_arm_controller.sv
// Armed trigger sequencer: fires one cycle after a masked rising edge, then holds off.
// All outputs registered; no backpressure, arm outside IDLE is dropped.
module trigger_arm_controller
    import trigger_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    trigger_arm_controller_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fired_ch_q;
    logic [CNT_W-1:0]  timeout_q;
    logic [CNT_W-1:0]  holdoff_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  trig_cnt;
    logic              auto_q;
    logic              armed_q;
    logic              busy_q;
    logic              fired_q;
    logic              timed_out_q;
    logic              wait_expired;
    logic              hold_done;

    rising_edge_bank #(.NUM_CH(NUM_CH)) u_edges (
        .clk       (clk),
        .reset     (reset),
        .signal_in (bus.signal_in),
        .mask      (mask_q),
        .edge_vec  (rise)
    );

    // Counters hold (cycles already spent - 1) in the phase, so +1 equals the limit on the last cycle.
    assign wait_expired = (timeout_q != '0) && ((wait_cnt + CNT_W'(1)) == timeout_q);
    assign hold_done    = ((hold_cnt + CNT_W'(1)) == holdoff_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            fired_ch_q  <= '0;
            timeout_q   <= '0;
            holdoff_q   <= '0;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            trig_cnt    <= '0;
            auto_q      <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            fired_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            fired_q     <= 1'b0;
            timed_out_q <= 1'b0;
            if (bus.abort) begin
                state   <= ST_IDLE;
                armed_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.arm) begin
                            mask_q    <= bus.ch_mask;
                            timeout_q <= bus.timeout_cycles;
                            holdoff_q <= bus.holdoff_cycles;
                            auto_q    <= bus.auto_rearm;
                            wait_cnt  <= '0;
                            state     <= ST_WAIT;
                            armed_q   <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        // Edge takes priority over a same-cycle timeout.
                        if (rise != '0) begin
                            state      <= ST_FIRE;
                            armed_q    <= 1'b0;
                            fired_q    <= 1'b1;
                            fired_ch_q <= rise;
                            if (trig_cnt != CNT_MAX) begin
                                trig_cnt <= trig_cnt + CNT_W'(1);
                            end
                        end else if (wait_expired) begin
                            state       <= ST_IDLE;
                            armed_q     <= 1'b0;
                            busy_q      <= 1'b0;
                            timed_out_q <= 1'b1;
                        end else if (timeout_q != '0) begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    ST_FIRE: begin
                        if (holdoff_q != '0) begin
                            state    <= ST_HOLDOFF;
                            hold_cnt <= '0;
                        end else if (auto_q) begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                            armed_q  <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (!hold_done) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end else if (auto_q) begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                            armed_q  <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.armed      = armed_q;
    assign bus.busy       = busy_q;
    assign bus.fired      = fired_q;
    assign bus.fired_ch   = fired_ch_q;
    assign bus.timed_out  = timed_out_q;
    assign bus.trig_count = trig_cnt;

endmodule
